// File: rtl/can_frame_tail_tx.sv
// ---------------------------------------------------------------------------
// can_frame_tail_tx
//
// Transmit-side frame-tail sequencer for the CAN channel unit. After the ACK
// slot it drives the ACK delimiter, the 7-bit End-Of-Frame and the 3-bit
// intermission recessive. It watches the bus read-back the whole time and
// answers a forbidden dominant bit with an active error flag or an overload
// flag, each followed by its delimiter. It also reports when the node may
// start the next frame.
//
// Ports
//   clk            system clock
//   resetN         synchronous, active-low reset
//   start          one-cycle pulse inside the ACK-delimiter bit, before its
//                  first sample pulse
//   txPoint        one-cycle pulse at the start of each bit time; dOut only
//                  changes here
//   samplePulse    sample strobe (3 per bit or 1 per bit)
//   rateSelector   1: three-point majority sampling, 0: single sample
//   dIn            bus read-back, 1 = recessive
//   dOut           TX drive, 1 = recessive
//   busy           high in every state except IDLE and READY
//   txReady        high in READY
//   frameDone      pulse when the 7th EOF bit is sampled recessive
//   errorPulse     pulse on entry to ERRFLAG
//   overloadPulse  pulse on entry to OVLFLAG
//   sofSeen        pulse on a dominant bit in intermission bit 3 (or in READY)
//   DBG            {sample state[1:0], main state[3:0], 2'b00}
// ---------------------------------------------------------------------------
module can_frame_tail_tx (
  input  logic       clk,
  input  logic       resetN,
  input  logic       start,
  input  logic       txPoint,
  input  logic       samplePulse,
  input  logic       rateSelector,
  input  logic       dIn,
  output logic       dOut,
  output logic       busy,
  output logic       txReady,
  output logic       frameDone,
  output logic       errorPulse,
  output logic       overloadPulse,
  output logic       sofSeen,
  output logic [7:0] DBG
);

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S1     = 2'd1,
    S2     = 2'd2,
    S3     = 2'd3
  } samp_t;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_READY   = 4'd1,
    ST_ACKDEL  = 4'd2,
    ST_EOF     = 4'd3,
    ST_ERRFLAG = 4'd4,
    ST_OVLFLAG = 4'd5,
    ST_DELIM   = 4'd6,
    ST_IFS     = 4'd7
  } state_t;

  // ---------------------------------------------------------------------
  // Sampler
  // ---------------------------------------------------------------------
  samp_t      samp_q, samp_d;
  logic [2:0] smp_q, smp_d;
  logic       bitValid;
  logic       bitVal;

  always_comb begin
    samp_d = samp_q;
    smp_d  = smp_q;
    unique case (samp_q)
      S_INIT: begin
        // The sampling mode is chosen here only, so a rateSelector change
        // never splits a bit between the two modes.
        if (samplePulse) begin
          if (rateSelector) begin
            smp_d[0] = dIn;
            samp_d   = S1;
          end else begin
            smp_d  = {3{dIn}};
            samp_d = S3;
          end
        end
      end
      S1: begin
        if (samplePulse) begin
          smp_d[1] = dIn;
          samp_d   = S2;
        end
      end
      S2: begin
        if (samplePulse) begin
          smp_d[2] = dIn;
          samp_d   = S3;
        end
      end
      // One-cycle decision slot; a strobe landing here is dropped.
      S3:      samp_d = S_INIT;
      default: samp_d = S_INIT;
    endcase
  end

  assign bitValid = (samp_q == S3);
  assign bitVal   = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) |
                    (smp_q[1] & smp_q[2]);

  // ---------------------------------------------------------------------
  // Main FSM
  // ---------------------------------------------------------------------
  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] fcnt_q, fcnt_d;
  logic       dout_q, dout_d;
  logic       busy_q, busy_d;
  logic       ready_q, ready_d;
  logic       frame_q, frame_d;
  logic       err_q, err_d;
  logic       ovl_q, ovl_d;
  logic       sof_q, sof_d;

  function automatic logic [3:0] inc4(input logic [3:0] c);
    return (c == 4'hF) ? c : c + 4'd1;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fcnt_d  = fcnt_q;
    dout_d  = dout_q;
    frame_d = 1'b0;
    err_d   = 1'b0;
    ovl_d   = 1'b0;
    sof_d   = 1'b0;

    // Bit decisions.
    if (bitValid) begin
      unique case (state_q)
        ST_READY: begin
          if (!bitVal) begin
            sof_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_ACKDEL: begin
          if (bitVal) begin
            state_d = ST_EOF;
            cnt_d   = '0;
          end else begin
            state_d = ST_ERRFLAG;
            err_d   = 1'b1;
            fcnt_d  = '0;
          end
        end
        ST_EOF: begin
          if (bitVal) begin
            if (inc4(cnt_q) == 4'd7) begin
              frame_d = 1'b1;
              state_d = ST_IFS;
              cnt_d   = '0;
            end else begin
              cnt_d = inc4(cnt_q);
            end
          end else begin
            state_d = ST_ERRFLAG;
            err_d   = 1'b1;
            fcnt_d  = '0;
          end
        end
        ST_DELIM: begin
          if (bitVal) begin
            if (inc4(cnt_q) == 4'd8) begin
              state_d = ST_IFS;
              cnt_d   = '0;
            end else begin
              cnt_d = inc4(cnt_q);
            end
          end else begin
            // Another node is still flagging; restart the delimiter.
            cnt_d = '0;
          end
        end
        ST_IFS: begin
          if (bitVal) begin
            if (inc4(cnt_q) == 4'd3) begin
              state_d = ST_READY;
              cnt_d   = '0;
            end else begin
              cnt_d = inc4(cnt_q);
            end
          end else if (cnt_q == 4'd2) begin
            sof_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_OVLFLAG;
            ovl_d   = 1'b1;
            fcnt_d  = '0;
          end
        end
        default: ;
      endcase
    end

    // start overrides a same-cycle READY bit decision.
    if (start && (state_q == ST_IDLE || state_q == ST_READY)) begin
      state_d = ST_ACKDEL;
      cnt_d   = '0;
      sof_d   = 1'b0;
    end

    // Drive updates act on the post-decision state, so a bit decision and a
    // txPoint in the same cycle both take effect.
    if (txPoint) begin
      if (state_d == ST_ERRFLAG || state_d == ST_OVLFLAG) begin
        if (fcnt_d >= 4'd6) begin
          dout_d  = 1'b1;
          cnt_d   = '0;
          state_d = ST_DELIM;
        end else begin
          dout_d = 1'b0;
          fcnt_d = inc4(fcnt_d);
        end
      end else begin
        dout_d = 1'b1;
      end
    end

    busy_d  = !(state_d == ST_IDLE || state_d == ST_READY);
    ready_d = (state_d == ST_READY);
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      samp_q  <= S_INIT;
      smp_q   <= '1;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      fcnt_q  <= '0;
      dout_q  <= 1'b1;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      frame_q <= 1'b0;
      err_q   <= 1'b0;
      ovl_q   <= 1'b0;
      sof_q   <= 1'b0;
    end else begin
      samp_q  <= samp_d;
      smp_q   <= smp_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fcnt_q  <= fcnt_d;
      dout_q  <= dout_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      frame_q <= frame_d;
      err_q   <= err_d;
      ovl_q   <= ovl_d;
      sof_q   <= sof_d;
    end
  end

  assign dOut          = dout_q;
  assign busy          = busy_q;
  assign txReady       = ready_q;
  assign frameDone     = frame_q;
  assign errorPulse    = err_q;
  assign overloadPulse = ovl_q;
  assign sofSeen       = sof_q;
  assign DBG           = {samp_q, state_q, 2'b00};

endmodule

// File: tb/tb_can_frame_tail_tx.sv
module tb_can_frame_tail_tx;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       start = 1'b0;
  logic       txPoint = 1'b0;
  logic       samplePulse = 1'b0;
  logic       rateSelector = 1'b1;
  logic       dIn = 1'b1;
  logic       dOut, busy, txReady, frameDone, errorPulse, overloadPulse, sofSeen;
  logic [7:0] DBG;

  int total = 0;
  int bad = 0;
  int dom_cycles = 0;

  can_frame_tail_tx dut (
    .clk          (clk),
    .resetN       (resetN),
    .start        (start),
    .txPoint      (txPoint),
    .samplePulse  (samplePulse),
    .rateSelector (rateSelector),
    .dIn          (dIn),
    .dOut         (dOut),
    .busy         (busy),
    .txReady      (txReady),
    .frameDone    (frameDone),
    .errorPulse   (errorPulse),
    .overloadPulse(overloadPulse),
    .sofSeen      (sofSeen),
    .DBG          (DBG)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (dOut === 1'b0) dom_cycles = dom_cycles + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // One bit time: txPoint, gap, then the sample strobes. Returns just after
  // the edge where the bit decision lands. dtx is dOut right after txPoint.
  task automatic bit_time(input logic [2:0] smp, output logic dtx);
    txPoint = 1'b1;
    tick();
    txPoint = 1'b0;
    dtx = dOut;
    tick();
    if (rateSelector) begin
      for (int i = 0; i < 3; i++) begin
        dIn = smp[i];
        samplePulse = 1'b1;
        tick();
        samplePulse = 1'b0;
        dIn = 1'b1;
        tick();
      end
    end else begin
      dIn = smp[0];
      samplePulse = 1'b1;
      tick();
      samplePulse = 1'b0;
      dIn = 1'b1;
      tick();
    end
  endtask

  task automatic run_bits(input int n);
    logic d;
    for (int i = 0; i < n; i++) bit_time(3'b111, d);
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    start = 1'b1;
    tick();
    tick();
    total++; if (dOut !== 1'b1) begin bad++; $display("FAIL reset_dout: got %b want 1", dOut); end
    total++; if ({busy, txReady, frameDone, errorPulse, overloadPulse, sofSeen} !== 6'b0) begin
      bad++; $display("FAIL reset_flags: got %b want 000000",
                      {busy, txReady, frameDone, errorPulse, overloadPulse, sofSeen});
    end
    total++; if (DBG !== 8'h00) begin bad++; $display("FAIL reset_dbg: got %h want 00", DBG); end
    resetN = 1'b1;
    start = 1'b0;
    tick();
    total++; if (DBG !== 8'h00) begin bad++; $display("FAIL reset_start_ignored: DBG %h want 00", DBG); end
  endtask

  task automatic test_sampler();
    samplePulse = 1'b1;
    tick();
    tick();
    tick();
    total++; if (DBG !== 8'hC0) begin bad++; $display("FAIL samp_s3: DBG %h want c0", DBG); end
    tick();
    samplePulse = 1'b0;
    total++; if (DBG !== 8'h00) begin bad++; $display("FAIL samp_drop_in_s3: DBG %h want 00", DBG); end
    samplePulse = 1'b1;
    tick();
    samplePulse = 1'b0;
    total++; if (DBG !== 8'h40) begin bad++; $display("FAIL samp_s1: DBG %h want 40", DBG); end
    samplePulse = 1'b1;
    tick();
    tick();
    samplePulse = 1'b0;
    tick();
    total++; if (DBG !== 8'h00) begin bad++; $display("FAIL samp_back_init: DBG %h want 00", DBG); end
  endtask

  task automatic test_clean_tail();
    int d0;
    logic d;
    d0 = dom_cycles;
    start_frame();
    total++; if (DBG !== 8'h08 || busy !== 1'b1) begin
      bad++; $display("FAIL clean_ackdel: DBG %h busy %b want 08 1", DBG, busy);
    end
    bit_time(3'b111, d);
    total++; if (DBG !== 8'h0C) begin bad++; $display("FAIL clean_eof: DBG %h want 0c", DBG); end
    run_bits(6);
    total++; if (frameDone !== 1'b0 || DBG !== 8'h0C) begin
      bad++; $display("FAIL clean_eof6: frameDone %b DBG %h want 0 0c", frameDone, DBG);
    end
    bit_time(3'b111, d);
    total++; if (frameDone !== 1'b1 || DBG !== 8'h1C) begin
      bad++; $display("FAIL clean_framedone: frameDone %b DBG %h want 1 1c", frameDone, DBG);
    end
    tick();
    total++; if (frameDone !== 1'b0) begin bad++; $display("FAIL clean_framedone_pulse: got %b want 0", frameDone); end
    run_bits(2);
    total++; if (txReady !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL clean_ifs2: txReady %b busy %b want 0 1", txReady, busy);
    end
    bit_time(3'b111, d);
    total++; if (txReady !== 1'b1 || busy !== 1'b0 || DBG !== 8'h04) begin
      bad++; $display("FAIL clean_ready: txReady %b busy %b DBG %h want 1 0 04", txReady, busy, DBG);
    end
    total++; if (dom_cycles - d0 !== 0) begin
      bad++; $display("FAIL clean_no_dominant: cycles %0d want 0", dom_cycles - d0);
    end
  endtask

  task automatic test_eof_error();
    int d0;
    int zeros;
    logic d;
    d0 = dom_cycles;
    start_frame();
    run_bits(4);
    bit_time(3'b000, d);
    total++; if (errorPulse !== 1'b1 || DBG !== 8'h10) begin
      bad++; $display("FAIL err_entry: errorPulse %b DBG %h want 1 10", errorPulse, DBG);
    end
    zeros = 0;
    for (int i = 0; i < 6; i++) begin
      bit_time(3'b111, d);
      if (d === 1'b0) zeros++;
    end
    total++; if (zeros !== 6) begin bad++; $display("FAIL err_flag_bits: got %0d want 6", zeros); end
    bit_time(3'b111, d);
    total++; if (d !== 1'b1 || DBG !== 8'h18) begin
      bad++; $display("FAIL err_delim: dOut %b DBG %h want 1 18", d, DBG);
    end
    run_bits(6);
    total++; if (DBG !== 8'h18) begin bad++; $display("FAIL err_delim7: DBG %h want 18", DBG); end
    bit_time(3'b111, d);
    total++; if (DBG !== 8'h1C) begin bad++; $display("FAIL err_ifs: DBG %h want 1c", DBG); end
    run_bits(3);
    total++; if (txReady !== 1'b1) begin bad++; $display("FAIL err_ready: txReady %b want 1", txReady); end
    total++; if (dom_cycles - d0 !== 48) begin
      bad++; $display("FAIL err_dominant_cycles: got %0d want 48", dom_cycles - d0);
    end
  endtask

  task automatic test_overload();
    int zeros;
    logic d;
    start_frame();
    run_bits(8);
    total++; if (frameDone !== 1'b1) begin bad++; $display("FAIL ovl_framedone: got %b want 1", frameDone); end
    bit_time(3'b111, d);
    bit_time(3'b000, d);
    total++; if (overloadPulse !== 1'b1 || DBG !== 8'h14) begin
      bad++; $display("FAIL ovl_entry: overloadPulse %b DBG %h want 1 14", overloadPulse, DBG);
    end
    zeros = 0;
    for (int i = 0; i < 6; i++) begin
      bit_time(3'b111, d);
      if (d === 1'b0) zeros++;
    end
    total++; if (zeros !== 6) begin bad++; $display("FAIL ovl_flag_bits: got %0d want 6", zeros); end
    bit_time(3'b111, d);
    total++; if (d !== 1'b1 || DBG !== 8'h18) begin
      bad++; $display("FAIL ovl_delim: dOut %b DBG %h want 1 18", d, DBG);
    end
    bit_time(3'b111, d);
    bit_time(3'b000, d);
    total++; if (DBG !== 8'h18) begin bad++; $display("FAIL ovl_delim_dominant: DBG %h want 18", DBG); end
    run_bits(7);
    total++; if (DBG !== 8'h18) begin bad++; $display("FAIL ovl_delim_restart: DBG %h want 18", DBG); end
    bit_time(3'b111, d);
    total++; if (DBG !== 8'h1C) begin bad++; $display("FAIL ovl_ifs: DBG %h want 1c", DBG); end
    run_bits(3);
    total++; if (txReady !== 1'b1) begin bad++; $display("FAIL ovl_ready: txReady %b want 1", txReady); end
  endtask

  task automatic test_sof();
    logic d;
    bit_time(3'b000, d);
    total++; if (sofSeen !== 1'b1 || DBG !== 8'h00) begin
      bad++; $display("FAIL sof_ready: sofSeen %b DBG %h want 1 00", sofSeen, DBG);
    end
    start_frame();
    run_bits(10);
    bit_time(3'b000, d);
    total++; if (sofSeen !== 1'b1 || DBG !== 8'h00 || busy !== 1'b0 || txReady !== 1'b0) begin
      bad++; $display("FAIL sof_ifs3: sofSeen %b DBG %h busy %b txReady %b want 1 00 0 0",
                      sofSeen, DBG, busy, txReady);
    end
    tick();
    total++; if (sofSeen !== 1'b0) begin bad++; $display("FAIL sof_pulse: got %b want 0", sofSeen); end
  endtask

  task automatic test_majority();
    logic d;
    start_frame();
    run_bits(2);
    bit_time(3'b101, d);
    total++; if (DBG !== 8'h0C || errorPulse !== 1'b0) begin
      bad++; $display("FAIL maj_101: DBG %h errorPulse %b want 0c 0", DBG, errorPulse);
    end
    run_bits(5);
    total++; if (frameDone !== 1'b1) begin bad++; $display("FAIL maj_framedone: got %b want 1", frameDone); end
    run_bits(3);
    rateSelector = 1'b0;
    start_frame();
    bit_time(3'b111, d);
    total++; if (DBG !== 8'h0C) begin bad++; $display("FAIL single_ackdel: DBG %h want 0c", DBG); end
    bit_time(3'b110, d);
    total++; if (DBG !== 8'h10 || errorPulse !== 1'b1) begin
      bad++; $display("FAIL single_err: DBG %h errorPulse %b want 10 1", DBG, errorPulse);
    end
  endtask

  task automatic test_reset_mid_flag();
    logic d;
    run_bits(2);
    bit_time(3'b111, d);
    total++; if (d !== 1'b0) begin bad++; $display("FAIL rst_flag_active: dOut %b want 0", d); end
    resetN = 1'b0;
    tick();
    total++; if (dOut !== 1'b1 || DBG !== 8'h00) begin
      bad++; $display("FAIL rst_mid_flag: dOut %b DBG %h want 1 00", dOut, DBG);
    end
    total++; if ({frameDone, errorPulse, overloadPulse, sofSeen, busy} !== 5'b0) begin
      bad++; $display("FAIL rst_mid_pulses: got %b want 00000",
                      {frameDone, errorPulse, overloadPulse, sofSeen, busy});
    end
    resetN = 1'b1;
    tick();
    start_frame();
    total++; if (DBG !== 8'h08 || busy !== 1'b1) begin
      bad++; $display("FAIL rst_restart: DBG %h busy %b want 08 1", DBG, busy);
    end
  endtask

  initial begin
    test_reset();
    test_sampler();
    test_clean_tail();
    test_eof_error();
    test_overload();
    test_sof();
    test_majority();
    test_reset_mid_flag();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/can_frame_tail_tx.md
# can_frame_tail_tx

Transmit-side frame-tail sequencer for the CAN channel unit. Once the controller finishes the ACK slot, it:
- drives the ACK delimiter, the 7-bit End-Of-Frame and the 3-bit intermission recessive on the TX line;
- monitors the bus read-back throughout;
- generates an active error flag or an overload flag, with its delimiter, when a dominant bit appears where the protocol forbids one;
- reports when the node may start the next frame.

It is the transmitting counterpart of the receive-side interframe detector and uses the same 1- or 3-point bit sampling.

## Interface
- No parameters.
- clk  in  1  system clock
- resetN  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse, asserted during the ACK-delimiter bit before its first sample pulse
- txPoint  in  1  one-cycle pulse at the start of each bit time; dOut may change only here
- samplePulse  in  1  sample strobe, 3 per bit (rateSelector=1) or 1 per bit (rateSelector=0)
- rateSelector  in  1  1: three sample points with majority vote; 0: single sample
- dIn  in  1  bus read-back, 1 = recessive
- dOut  out  1  TX drive, 1 = recessive
- busy  out  1  high in every state except IDLE and READY
- txReady  out  1  high in READY
- frameDone  out  1  one-cycle pulse when the 7th EOF bit is sampled recessive
- errorPulse  out  1  one-cycle pulse on entry to ERRFLAG
- overloadPulse  out  1  one-cycle pulse on entry to OVLFLAG
- sofSeen  out  1  one-cycle pulse on a dominant bit in intermission bit 3
- DBG  out  8  {sample state[1:0], main state[3:0], 2'b00}

## Operation
**Sampler** (runs continuously, independent of the main FSM):
- States: S_INIT, S1, S2, S3.
- rateSelector=1: each samplePulse captures dIn and advances S_INIT→S1→S2→S3.
- rateSelector=0: one samplePulse goes S_INIT→S3 and captures dIn into all three sample registers.
- S3 lasts exactly one cycle, then returns to S_INIT; that cycle is bitValid.
- bitVal = majority of the three samples.

**Main FSM** (bit decisions only on bitValid; drive changes only on txPoint):
- **IDLE / READY**
  - start → ACKDEL, cnt=0. start in any other state is ignored.
  - IDLE ignores the bus.
  - READY: bitValid with bitVal=0 → pulse sofSeen, go IDLE.
- **ACKDEL**: drive 1.
  - bitVal=1 → EOF, cnt=0.
  - bitVal=0 → ERRFLAG.
- **EOF**: drive 1.
  - bitVal=1 → cnt++; when cnt reaches 7, pulse frameDone, go IFS with cnt=0.
  - bitVal=0 on any of bits 1–7 → ERRFLAG (transmitter form error).
- **ERRFLAG / OVLFLAG**
  - fcnt=0 on entry.
  - Each txPoint: dOut=0, fcnt++.
  - The txPoint after fcnt reaches 6 sets dOut=1, clears cnt, and goes DELIM.
  - bitValid is ignored.
- **DELIM**: drive 1.
  - bitVal=1 → cnt++.
  - bitVal=0 → cnt=0 (superimposed flags from other nodes).
  - cnt reaches 8 → IFS, cnt=0.
- **IFS**: drive 1.
  - bitVal=1 → cnt++; cnt reaches 3 → READY.
  - bitVal=0 with cnt=0 or 1 → OVLFLAG.
  - bitVal=0 with cnt=2 → pulse sofSeen, go IDLE.
- Counters are 4 bits and saturate; they can never wrap under legal sequencing.

## Timing
Reset values:
- State IDLE, sampler S_INIT, all counters 0.
- dOut=1; busy, txReady, frameDone, errorPulse, overloadPulse, sofSeen all 0.

Latency:
- State transitions take effect the cycle after bitValid (registered).
- Pulses (frameDone, errorPulse, overloadPulse, sofSeen) are registered and aligned with the new state.
- Flag bits: dOut goes 0 at the first txPoint after entry into ERRFLAG/OVLFLAG and stays 0 for exactly 6 bit times. It is visible the cycle after the txPoint.

Boundary conditions:
- txPoint and bitValid in the same cycle: both are applied. The bitValid transition takes priority, and dOut is loaded from the post-transition drive value.
- samplePulse during S3 is dropped.
- A rateSelector change takes effect from the next S_INIT.
- resetN low mid-flag: dOut returns to 1 the next cycle.
- start during the reset cycle is ignored.

## Test plan
- **Clean tail**, rateSelector=1, dIn=1 throughout:
  - start → ACKDEL, 7 EOF bits, frameDone after bitValid #8.
  - txReady high after bitValid #11.
  - dOut never 0.
- **EOF form error**: dIn=0 at EOF bit 4:
  - errorPulse; dOut=0 for exactly 6 txPoints.
  - After 8 recessive bits plus 3 IFS bits, txReady=1.
- **Overload**: dIn=0 at IFS bit 2:
  - overloadPulse; 6 dominant bits out.
  - Delimiter counter resets when dIn=0 at delimiter bit 3, requiring 8 further recessive bits before IFS.
- **SOF in intermission**: dIn=0 at IFS bit 3 → sofSeen pulse, state IDLE, busy=0, txReady=0.
- **Majority vote** with samples 1,0,1 in EOF bit 2 → treated as recessive. With rateSelector=0, a single 0 sample → ERRFLAG.
- **Reset mid-ERRFLAG** after 3 dominant bits → next cycle dOut=1, DBG=0, all pulses 0; a further start is accepted.
